// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, counter/FSM bounce filter,
// registered press pulse, debounced level and wrapping press counter.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       sClk,
  input  logic       sReset,
  input  logic       sRawButton,
  output logic       sButton,
  output logic       sButtonLevel,
  output logic [7:0] sPressCount
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             sync1_r;
  logic             sync2_r;
  logic             press_s;
  logic             release_s;

  // Two-flop synchronizer for the asynchronous raw button line.
  always_ff @(posedge sClk or posedge sReset) begin
    if (sReset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sRawButton;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM state and consecutive-sample counter registers.
  always_ff @(posedge sClk or posedge sReset) begin
    if (sReset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, counter update and press/release event decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync2_r) begin
          state_s = PRESS_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_r) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = PRESSED;
          cnt_s   = CNT_ZERO;
          press_s = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_r) begin
          state_s = RELEASE_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = cnt_r;
        end
      end
      RELEASE_WAIT: begin
        // A single high sample means the release was bounce: back to held.
        if (sync2_r) begin
          state_s   = PRESSED;
          cnt_s     = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = IDLE;
          cnt_s     = CNT_ZERO;
          release_s = 1'b1;
        end else begin
          cnt_s     = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Registered outputs driven from the accepted press/release events.
  always_ff @(posedge sClk or posedge sReset) begin
    if (sReset) begin
      sButton      <= 1'b0;
      sButtonLevel <= 1'b0;
      sPressCount  <= 8'd0;
    end else begin
      sButton <= press_s;
      if (press_s) begin
        sButtonLevel <= 1'b1;
        sPressCount  <= sPressCount + 8'd1;
      end else if (release_s) begin
        sButtonLevel <= 1'b0;
        sPressCount  <= sPressCount;
      end else begin
        sButtonLevel <= sButtonLevel;
        sPressCount  <= sPressCount;
      end
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with hand-computed edge timing,
// plus a small on/off light model fed by the press pulse.
module tb_button_debounce;

  logic       sClk = 1'b0;
  logic       sReset;
  logic       sRawButton;
  logic       sButton;
  logic       sButtonLevel;
  logic [7:0] sPressCount;

  int   tests   = 0;
  int   fails   = 0;
  int   pulses  = 0;
  int   toggles = 0;
  int   p0;
  logic luz      = 1'b0;
  logic luz_prev = 1'b0;
  logic luz_start;

  always #5 sClk = ~sClk;

  button_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .sClk         (sClk),
    .sReset       (sReset),
    .sRawButton   (sRawButton),
    .sButton      (sButton),
    .sButtonLevel (sButtonLevel),
    .sPressCount  (sPressCount)
  );

  // On/off light driven by the press pulse.
  always @(posedge sClk or posedge sReset) begin
    if (sReset) luz <= 1'b0;
    else if (sButton) luz <= ~luz;
  end

  // Pulse and light-toggle monitors, sampled away from the active edge.
  always @(negedge sClk) begin
    if (sButton === 1'b1) pulses++;
    if (luz !== luz_prev) toggles++;
    luz_prev = luz;
  end

  task automatic tick();
    @(posedge sClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    sReset     = 1'b1;
    sRawButton = 1'b0;
    tick();
    tick();
    check("reset_button", {31'd0, sButton}, 32'd0);
    check("reset_level", {31'd0, sButtonLevel}, 32'd0);
    check("reset_count", {24'd0, sPressCount}, 32'd0);

    // Clean press held high: pulse at edge 6 only.
    sReset     = 1'b0;
    sRawButton = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("press_pulse", {31'd0, sButton}, (e == 6) ? 32'd1 : 32'd0);
      check("press_level", {31'd0, sButtonLevel}, (e >= 6) ? 32'd1 : 32'd0);
      check("press_count", {24'd0, sPressCount}, (e >= 6) ? 32'd1 : 32'd0);
    end
    p0 = pulses;
    repeat (50) tick();
    check("hold_no_repulse", p0 - pulses, 32'd0);
    check("hold_count", {24'd0, sPressCount}, 32'd1);

    // Clean release: level drops at edge 6, no pulse.
    sRawButton = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("release_level", {31'd0, sButtonLevel}, (e == 6) ? 32'd0 : 32'd1);
      check("release_pulse", {31'd0, sButton}, 32'd0);
    end
    check("release_count", {24'd0, sPressCount}, 32'd1);

    // Bounce 1,0,1,1,0 then stable high.
    sRawButton = 1'b1; tick(); check("bounce_quiet", {31'd0, sButton | sButtonLevel}, 32'd0);
    sRawButton = 1'b0; tick(); check("bounce_quiet", {31'd0, sButton | sButtonLevel}, 32'd0);
    sRawButton = 1'b1; tick(); check("bounce_quiet", {31'd0, sButton | sButtonLevel}, 32'd0);
    sRawButton = 1'b1; tick(); check("bounce_quiet", {31'd0, sButton | sButtonLevel}, 32'd0);
    sRawButton = 1'b0; tick(); check("bounce_quiet", {31'd0, sButton | sButtonLevel}, 32'd0);
    sRawButton = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("bounce_pulse", {31'd0, sButton}, (e == 6) ? 32'd1 : 32'd0);
    end
    check("bounce_count", {24'd0, sPressCount}, 32'd2);

    // Three-sample low glitch while held: no change.
    sRawButton = 1'b0;
    repeat (3) begin
      tick();
      check("glitch_level", {31'd0, sButtonLevel}, 32'd1);
    end
    sRawButton = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("glitch_level", {31'd0, sButtonLevel}, 32'd1);
      check("glitch_pulse", {31'd0, sButton}, 32'd0);
    end
    sRawButton = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("true_release_level", {31'd0, sButtonLevel}, (e == 6) ? 32'd0 : 32'd1);
      check("true_release_pulse", {31'd0, sButton}, 32'd0);
    end
    check("true_release_count", {24'd0, sPressCount}, 32'd2);

    // 256 clean presses from zero: counter wraps on the last one.
    sReset = 1'b1;
    #1;
    sReset = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 256; i++) begin
      sRawButton = 1'b1;
      repeat (8) tick();
      sRawButton = 1'b0;
      repeat (8) tick();
      if (i == 254) check("count_255", {24'd0, sPressCount}, 32'd255);
    end
    check("count_wrap", {24'd0, sPressCount}, 32'd0);
    check("wrap_pulses", pulses - p0, 32'd256);

    // Reset inside PRESS_WAIT.
    sRawButton = 1'b1;
    repeat (8) tick();
    sRawButton = 1'b0;
    repeat (8) tick();
    check("pre_reset_count", {24'd0, sPressCount}, 32'd1);
    sRawButton = 1'b1;
    repeat (4) tick();
    sReset = 1'b1;
    #1;
    check("rst_pw_count", {24'd0, sPressCount}, 32'd0);
    check("rst_pw_outs", {30'd0, sButton, sButtonLevel}, 32'd0);
    tick();
    sReset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("post_rst_pulse", {31'd0, sButton}, (e == 6) ? 32'd1 : 32'd0);
    end
    check("post_rst_count", {24'd0, sPressCount}, 32'd1);

    // Reset during the pulse cycle truncates it immediately.
    sReset = 1'b1;
    #1;
    check("rst_pulse_button", {31'd0, sButton}, 32'd0);
    check("rst_pulse_level", {31'd0, sButtonLevel}, 32'd0);
    check("rst_pulse_count", {24'd0, sPressCount}, 32'd0);
    #1;
    sReset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("rearm_pulse", {31'd0, sButton}, (e == 6) ? 32'd1 : 32'd0);
    end
    check("rearm_count", {24'd0, sPressCount}, 32'd1);

    // Three bouncy presses into the light toggle.
    sRawButton = 1'b0;
    repeat (8) tick();
    luz_start = luz;
    toggles   = 0;
    repeat (3) begin
      sRawButton = 1'b1; tick();
      sRawButton = 1'b0; tick();
      sRawButton = 1'b1; tick();
      sRawButton = 1'b1; tick();
      sRawButton = 1'b0; tick();
      sRawButton = 1'b1; repeat (8) tick();
      sRawButton = 1'b0; tick();
      sRawButton = 1'b1; tick();
      sRawButton = 1'b0; repeat (8) tick();
    end
    check("light_toggles", toggles, 32'd3);
    check("light_state", {31'd0, luz}, {31'd0, ~luz_start});
    check("light_count", {24'd0, sPressCount}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
